// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifetch_pkg;

    localparam int unsigned FETCH_XLEN = 32;
    localparam int unsigned PC_STEP    = 4;

    typedef enum logic [1:0] {
        REQ     = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] instr;
        logic [FETCH_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO of fetch entries; pointers carry an extra wrap bit for full/empty.
module ifq_fifo
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  wdata,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    fetch_entry_t  mem [DEPTH];
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + CW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + CW'(1);
        end
    end

    // Storage needs no reset; the head is masked by the caller while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: sequential PC, one outstanding read, buffered words to decode.
// Optional counters enabled by defining IFETCH_QUEUE_PERF_EN.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int unsigned       XLEN       = 32,
    parameter logic [XLEN-1:0]   RESET_PC   = 32'h0000_0000,
    parameter int unsigned       FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            resp_valid,
    input  logic [XLEN-1:0] resp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
`ifdef IFETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall,
    output logic [15:0]     perf_flush
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e    state;
    fetch_state_e    state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pend_pc;
    logic [CW-1:0]   count;
    fetch_entry_t    head;
    fetch_entry_t    wdata;
    logic            fire;
    logic            push;
    logic            pop;

    // A slot is implicitly reserved while a request is outstanding, so count alone gates issue.
    assign req_valid = rst && (state == REQ) && (count < CW'(FIFO_DEPTH)) && !redirect_valid;
    assign req_addr  = pc;
    assign fire      = req_valid && req_ready;
    assign push      = (state == WAIT) && resp_valid && !redirect_valid;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready && !redirect_valid;
    assign out_instr = out_valid ? head.instr : '0;
    assign out_pc    = out_valid ? head.pc : '0;
    assign wdata     = '{instr: resp_data, pc: pend_pc};

    ifq_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wdata),
        .count (count),
        .head  (head)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= REQ;
        else      state <= state_nxt;
    end

    // A response always closes the outstanding request; redirect only decides whether it is kept.
    always_comb begin
        state_nxt = state;
        case (state)
            REQ:     if (fire) state_nxt = WAIT;
            WAIT: begin
                if (resp_valid)          state_nxt = REQ;
                else if (redirect_valid) state_nxt = DISCARD;
            end
            DISCARD: if (resp_valid) state_nxt = REQ;
            default: state_nxt = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc      <= RESET_PC;
            pend_pc <= '0;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (fire) begin
            pc      <= pc + XLEN'(PC_STEP);
            pend_pc <= pc;
        end
    end

`ifdef IFETCH_QUEUE_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
            perf_flush   <= '0;
        end else begin
            if (push)                   perf_fetched <= perf_fetched + 32'd1;
            if (out_ready && !out_valid) perf_stall  <= perf_stall + 32'd1;
            if (redirect_valid)         perf_flush   <= perf_flush + 16'd1;
        end
    end
`else
    // Counters are absent in this build.
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: queue-based reference model plus directed scenarios.
module tb_ifetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
`ifdef IFETCH_QUEUE_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
    logic [15:0] perf_flush;
`endif

    always #5 clk = ~clk;

    ifetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IFETCH_QUEUE_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall),
        .perf_flush     (perf_flush)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what has been fetched, what is owed by memory, what decode sees.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc = '0;
    logic [31:0] m_pend = '0;
    bit          m_known = 0;
    bit          m_busy = 0;
    bit          m_stale = 0;
    bit          m_zero = 0;
    bit          e_fire;
    bit          e_pop;
    logic [31:0] m_fetched = '0;
    logic [31:0] m_stall = '0;
    logic [15:0] m_flush = '0;

    always @(posedge clk) begin
        if (!rst) begin
            q.delete();
            m_pc = 32'h0;
            m_busy = 0;
            m_stale = 0;
            m_zero = 1;
            m_known = 1;
            m_fetched = '0;
            m_stall = '0;
            m_flush = '0;
        end else if (m_known) begin
            e_fire = !m_busy && (q.size() < DEPTH) && !redirect_valid && req_ready;
            e_pop  = (q.size() != 0) && out_ready && !redirect_valid;
            if (out_ready && q.size() == 0) m_stall = m_stall + 1;
            if (redirect_valid) begin
                m_flush = m_flush + 1;
                q.delete();
                m_pc = redirect_pc;
                if (m_busy && (m_stale || resp_valid)) begin
                    m_busy = 0;
                    m_stale = 0;
                end else if (m_busy) begin
                    m_stale = 1;
                end
            end else begin
                if (e_pop) void'(q.pop_front());
                if (m_busy && resp_valid) begin
                    if (!m_stale) begin
                        q.push_back('{resp_data, m_pend});
                        m_fetched = m_fetched + 1;
                        m_zero = 0;
                    end
                    m_busy = 0;
                    m_stale = 0;
                end
                if (e_fire) begin
                    m_pend = m_pc;
                    m_pc = m_pc + 32'd4;
                    m_busy = 1;
                end
            end
        end
    end

    // Compare outputs against the model every cycle, after inputs have settled.
    always @(negedge clk) begin
        #1;
        if (m_known) begin
            chk("req_valid", {31'd0, req_valid},
                {31'd0, rst && !m_busy && (q.size() < DEPTH) && !redirect_valid});
            if (rst && !m_busy && (q.size() < DEPTH) && !redirect_valid)
                chk("req_addr", req_addr, m_pc);
            chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
            if (q.size() != 0) begin
                chk("out_instr", out_instr, q[0].instr);
                chk("out_pc", out_pc, q[0].pc);
            end else if (m_zero) begin
                chk("out_instr_zero", out_instr, 32'h0);
                chk("out_pc_zero", out_pc, 32'h0);
            end
`ifdef IFETCH_QUEUE_PERF_EN
            chk("perf_fetched", perf_fetched, m_fetched);
            chk("perf_stall", perf_stall, m_stall);
            chk("perf_flush", {16'd0, perf_flush}, {16'd0, m_flush});
`endif
        end
    end

    // Auto memory: answers every accepted request one cycle later.
    bit          mem_auto = 0;
    bit          hit = 0;
    logic [31:0] hit_addr = '0;

    function automatic logic [31:0] word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_0013;
            32'h4:   return 32'h0010_0093;
            default: return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    always @(negedge clk) begin
        if (mem_auto) begin
            resp_valid = hit;
            resp_data  = word(hit_addr);
            #2;
            hit      = req_valid && req_ready;
            hit_addr = req_addr;
        end else begin
            hit = 0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    int          n;
    logic [31:0] last;

    initial begin
        // Reset state
        mem_auto = 1;
        req_ready = 1;
        out_ready = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Basic flow, k = 1
        #1;
        chk("t1_addr0", req_addr, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        chk("t1_instr0", out_instr, 32'h0000_0013);
        chk("t1_pc0", out_pc, 32'h0);
        chk("t1_addr4", req_addr, 32'h4);
        repeat (2) @(negedge clk);
        #1;
        chk("t1_instr1", out_instr, 32'h0010_0093);
        chk("t1_pc1", out_pc, 32'h4);

        // Back-pressure fills exactly the buffer
        out_ready = 0;
        do_reset();
        n = 0;
        last = '0;
        repeat (20) begin
            #1;
            if (req_valid && req_ready) begin
                n++;
                last = req_addr;
            end
            @(negedge clk);
        end
        chk("t2_req_count", n, 32'd4);
        chk("t2_last_addr", last, 32'hC);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        #1;
        chk("t2_req_after_pop", {31'd0, req_valid}, 32'd1);
        chk("t2_addr_after_pop", req_addr, 32'h10);
        out_ready = 1;
        repeat (12) @(negedge clk);

        // Redirect during WAIT, stale response later
        mem_auto = 0;
        do_reset();
        resp_valid = 0;
        #1;
        chk("t3_addr0", req_addr, 32'h0);
        @(negedge clk);
        redirect_valid = 1;
        redirect_pc = 32'h200;
        @(negedge clk);
        redirect_valid = 0;
        @(negedge clk);
        resp_valid = 1;
        resp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        resp_valid = 0;
        #1;
        chk("t3_stale_dropped", {31'd0, out_valid}, 32'd0);
        chk("t3_addr_redirect", req_addr, 32'h200);
        @(negedge clk);
        resp_valid = 1;
        resp_data = 32'hCAFE_0001;
        @(negedge clk);
        resp_valid = 0;
        #1;
        chk("t3_out_pc", out_pc, 32'h200);
        chk("t3_out_instr", out_instr, 32'hCAFE_0001);

        // Redirect together with resp_valid and pop, two entries queued
        out_ready = 0;
        do_reset();
        resp_valid = 0;
        @(negedge clk);
        resp_valid = 1;
        resp_data = 32'h1111_1111;
        @(negedge clk);
        resp_valid = 0;
        @(negedge clk);
        resp_valid = 1;
        resp_data = 32'h2222_2222;
        @(negedge clk);
        resp_valid = 0;
        @(negedge clk);
        resp_valid = 1;
        resp_data = 32'h3333_3333;
        redirect_valid = 1;
        redirect_pc = 32'h300;
        out_ready = 1;
        @(negedge clk);
        resp_valid = 0;
        redirect_valid = 0;
        #1;
        chk("t4_flushed", {31'd0, out_valid}, 32'd0);
        chk("t4_addr_redirect", req_addr, 32'h300);
        @(negedge clk);
        resp_valid = 1;
        resp_data = 32'h4444_4444;

        // PC wrap
        @(negedge clk);
        resp_valid = 0;
        redirect_valid = 1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 0;
        #1;
        chk("t5_addr_top", req_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        resp_valid = 1;
        resp_data = 32'h5555_5555;
        @(negedge clk);
        resp_valid = 0;
        #1;
        chk("t5_addr_wrap", req_addr, 32'h0);
        chk("t5_out_pc", out_pc, 32'hFFFF_FFFC);
        @(negedge clk);
        resp_valid = 1;
        resp_data = 32'h6666_6666;

        // Reset while a request is outstanding, then a late response
        @(negedge clk);
        resp_valid = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        rst = 1;
        req_ready = 0;
        resp_valid = 1;
        resp_data = 32'hBAD0_BAD0;
        @(negedge clk);
        resp_valid = 0;
        req_ready = 1;
        #1;
        chk("t6_late_ignored", {31'd0, out_valid}, 32'd0);
        chk("t6_addr_reset_pc", req_addr, 32'h0);
        @(negedge clk);
        resp_valid = 1;
        resp_data = 32'h0000_0013;
        @(negedge clk);
        resp_valid = 0;
        #1;
        chk("t6_out_instr", out_instr, 32'h0000_0013);
        chk("t6_out_pc", out_pc, 32'h0);
`ifdef IFETCH_QUEUE_PERF_EN
        chk("t6_perf_fetched", perf_fetched, 32'd1);
        chk("t6_perf_flush", {16'd0, perf_flush}, 32'd0);
`endif
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
